seq_alu: RTL

Parametrised, handshaked successor to the team's 3-operand, 2-bit-select combinational ALU.
- Takes three WIDTH-bit unsigned operands (a, b, c) and a 2-bit op; returns a 2*WIDTH-bit result.
- Multiply-accumulate is iterative (shift-add), not a combinational multiplier. All other ops complete in one cycle.
- Sits between an operand-issuing controller and a result consumer, using valid/ready on both sides.

---
 rtl/seq_alu.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked three-operand ALU with an iterative shift-add
// multiply-accumulate. Operands are captured on accept; MAC runs WIDTH
// shift-add iterations, the other ops resolve in the accept cycle.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand-side handshake (in_ready = state is IDLE)
//   a, b, c            WIDTH-bit unsigned operands
//   op                 00 MAC, 01 SUM3, 10 SHL, 11 MAX3
//   out_valid/out_ready result-side handshake
//   result             2*WIDTH-bit result, held until transferred
//   busy               high while an operation is in flight or unconsumed
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned SHW = $clog2(RW);
    localparam int unsigned CW  = $clog2(WIDTH);

    localparam logic [1:0] OP_MAC  = 2'b00;
    localparam logic [1:0] OP_SUM3 = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_MAX3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    logic [RW-1:0]    quick_result;
    logic [RW-1:0]    acc_add;
    logic [WIDTH-1:0] max_ab;

    // Single-cycle ops, evaluated on the live operands for capture at accept.
    always_comb begin
        quick_result = '0;
        max_ab       = (a > b) ? a : b;
        case (op)
            OP_SUM3: quick_result = RW'(a) + RW'(b) + RW'(c);
            OP_SHL:  quick_result = RW'(a) << c[SHW-1:0];
            OP_MAX3: quick_result = RW'((max_ab > c) ? max_ab : c);
            default: quick_result = '0;
        endcase
    end

    // One shift-add step: conditionally add the shifted multiplicand.
    always_comb begin
        acc_add = acc;
        if (mplier[0]) begin
            acc_add = acc + mcand;
        end
    end

    assign in_ready = (state == IDLE);

    // Control FSM with registered result-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        busy <= 1'b1;
                        if (op == OP_MAC) begin
                            acc    <= RW'(c);
                            mcand  <= RW'(a);
                            mplier <= b;
                            count  <= '0;
                            state  <= MUL;
                        end else begin
                            result    <= quick_result;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    // Always runs the full WIDTH iterations for fixed latency.
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        result    <= acc_add;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
